// File: rtl/burst_stim_gen_if.sv
// Signal bundle between burst_stim_gen (master) and the datapath block it exercises.
interface burst_stim_gen_if #(
    parameter int N = 21
);
    logic         start;
    logic [1:0]   mode;
    logic [N-1:0] sum_in;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         flit_valid;
    logic         pkt_first;
    logic         pkt_last;
    logic         measure_en;
    logic         busy;
    logic         done;
    logic [31:0]  cycle_cnt;
    logic [15:0]  err_cnt;

    // Handshake: flit_valid high means op_a/op_b carry a new flit this cycle. There is
    // no ready; the block under test must take every flit, and sum_in is sampled
    // CHK_LAT cycles after the flit that produced it.
    modport master (
        input  start, mode, sum_in,
        output op_a, op_b, flit_valid, pkt_first, pkt_last,
        output measure_en, busy, done, cycle_cnt, err_cnt
    );

    modport slave (
        output start, mode, sum_in,
        input  op_a, op_b, flit_valid, pkt_first, pkt_last,
        input  measure_en, busy, done, cycle_cnt, err_cnt
    );
endinterface

// File: rtl/burst_stim_gen.sv
// Burst-traffic stimulus engine: packets of pattern flits separated by idle gaps,
// a measurement window enable, and a latency-aligned check of the returned sum.
module burst_stim_gen #(
    parameter int          N        = 21,
    parameter int          PAYLOAD  = 20,
    parameter int          GAP      = 7,
    parameter int          NUM_PKTS = 10,
    parameter int          STRIDE   = 12,
    parameter int          CHK_LAT  = 0,
    parameter logic [31:0] SEED     = 32'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    burst_stim_gen_if.master bus,
    output logic [1:0]       state_dbg
);
    localparam int W      = 2 * N;
    localparam int L      = (W - 1) / STRIDE;
    localparam int PH_MAX = 2 * L;
    localparam int FW     = (PAYLOAD > 1) ? $clog2(PAYLOAD) : 1;
    localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int PW     = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
    localparam int PHW    = $clog2(PH_MAX + 1);
    localparam int REP    = (W + 31) / 32;

    localparam logic [FW-1:0]  FLIT_LAST = FW'(PAYLOAD - 1);
    localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP - 1);
    localparam logic [PW-1:0]  PKT_LAST  = PW'(NUM_PKTS - 1);
    localparam logic [PHW-1:0] PHASE_MAX = PHW'(PH_MAX);
    localparam logic [31:0]    LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [W-1:0] therm_word(input logic [PHW-1:0] p);
        logic [W-1:0] ones;
        ones = '1;
        if (p == '0)
            therm_word = '0;
        else if (int'(p) <= L)
            therm_word = ~(ones >> (int'(p) * STRIDE));
        else
            therm_word = ~(ones << ((PH_MAX + 1 - int'(p)) * STRIDE));
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [W-1:0] lfsr_word(input logic [31:0] s);
        logic [32*REP-1:0] r;
        r = {REP{s}};
        lfsr_word = r[W-1:0];
    endfunction

    state_t         state_q, state_d;
    logic [FW-1:0]  flit_q, flit_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [PW-1:0]  pkt_q, pkt_d;
    logic [1:0]     mode_q, mode_d;
    logic [PHW-1:0] phase_q, phase_nx;
    logic [31:0]    lfsr_q, lfsr_nx;
    logic [W-1:0]   word_q, word_nx, walk_nx;
    logic [31:0]    cyc_q;
    logic [15:0]    err_q;
    logic           launch, issue, pkt_start;
    logic           send, measure;
    logic [N-1:0]   exp_now, chk_exp;
    logic           chk_valid;

    assign send    = (state_q == S_SEND);
    assign measure = (state_q == S_SEND) || (state_q == S_GAP);

    // issue: a new flit is loaded into the output word at this edge
    always_comb begin
        state_d   = state_q;
        flit_d    = flit_q;
        gap_d     = gap_q;
        pkt_d     = pkt_q;
        mode_d    = mode_q;
        launch    = 1'b0;
        issue     = 1'b0;
        pkt_start = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    launch    = 1'b1;
                    issue     = 1'b1;
                    pkt_start = 1'b1;
                    state_d   = S_SEND;
                    mode_d    = bus.mode;
                    flit_d    = '0;
                    gap_d     = '0;
                    pkt_d     = '0;
                end
            end
            S_SEND: begin
                if (flit_q == FLIT_LAST) begin
                    if (GAP != 0) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else if (pkt_q == PKT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        pkt_d     = pkt_q + PW'(1);
                        flit_d    = '0;
                        issue     = 1'b1;
                        pkt_start = 1'b1;
                    end
                end else begin
                    flit_d = flit_q + FW'(1);
                    issue  = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (pkt_q == PKT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_SEND;
                        pkt_d     = pkt_q + PW'(1);
                        flit_d    = '0;
                        issue     = 1'b1;
                        pkt_start = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pattern for the flit about to be issued; the walking one rotates the live word.
    always_comb begin
        phase_nx = '0;
        if (pkt_start)
            phase_nx = PHW'(1);
        else if (phase_q != PHASE_MAX)
            phase_nx = phase_q + PHW'(1);
        lfsr_nx = launch ? SEED : lfsr_step(lfsr_q);
        walk_nx = launch ? W'(1) : {word_q[W-2:0], word_q[W-1]};
        word_nx = '0;
        case (mode_d)
            2'd0:    word_nx = therm_word(phase_nx);
            2'd1:    word_nx = lfsr_word(lfsr_nx);
            2'd2:    word_nx = walk_nx;
            default: word_nx = flit_d[0] ? '0 : '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            flit_q  <= '0;
            gap_q   <= '0;
            pkt_q   <= '0;
            mode_q  <= '0;
            phase_q <= '0;
            lfsr_q  <= SEED;
            word_q  <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            gap_q   <= gap_d;
            pkt_q   <= pkt_d;
            mode_q  <= mode_d;
            if (issue) begin
                phase_q <= phase_nx;
                lfsr_q  <= lfsr_nx;
                word_q  <= word_nx;
            end
            if (launch)
                cyc_q <= '0;
            else if (measure)
                cyc_q <= cyc_q + 32'd1;
        end
    end

    assign exp_now = word_q[N-1:0] + word_q[W-1:N];

    // Expected sums ride a shift pipe matching the latency of the block under test;
    // a new run drops anything still in flight from the previous one.
    if (CHK_LAT == 0) begin : g_chk_comb
        assign chk_valid = send;
        assign chk_exp   = exp_now;
    end else begin : g_chk_pipe
        logic [CHK_LAT-1:0] vpipe;
        logic [N-1:0]       epipe [CHK_LAT];

        always_ff @(posedge clk) begin
            if (rst) begin
                vpipe <= '0;
                for (int i = 0; i < CHK_LAT; i++)
                    epipe[i] <= '0;
            end else begin
                vpipe[0] <= send;
                epipe[0] <= exp_now;
                for (int i = 1; i < CHK_LAT; i++) begin
                    vpipe[i] <= vpipe[i-1] & ~launch;
                    epipe[i] <= epipe[i-1];
                end
            end
        end

        assign chk_valid = vpipe[CHK_LAT-1];
        assign chk_exp   = epipe[CHK_LAT-1];
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= '0;
        else if (launch)
            err_q <= '0;
        else if (chk_valid && (bus.sum_in != chk_exp) && (err_q != 16'hFFFF))
            err_q <= err_q + 16'd1;
    end

    assign bus.op_a       = word_q[N-1:0];
    assign bus.op_b       = word_q[W-1:N];
    assign bus.flit_valid = send;
    assign bus.pkt_first  = send && (flit_q == '0);
    assign bus.pkt_last   = send && (flit_q == FLIT_LAST);
    assign bus.measure_en = measure;
    assign bus.busy       = measure;
    assign bus.done       = (state_q == S_DONE);
    assign bus.cycle_cnt  = cyc_q;
    assign bus.err_cnt    = err_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_burst_stim_gen.sv
// Bench for burst_stim_gen: default generator, a latency-2 checker and a short
// back-to-back configuration, all compared against a bench-side pattern model.
module tb_burst_stim_gen;
    localparam int N      = 21;
    localparam int W      = 2 * N;
    localparam int P      = 20;
    localparam int G      = 7;
    localparam int NP     = 10;
    localparam int STRIDE = 12;
    localparam int LL     = (W - 1) / STRIDE;
    localparam int RUN    = NP * (P + G);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       start_m, start_l, start_s;
    logic [1:0] mode;
    logic       flip;
    int         sum_sel;
    logic [1:0] st_m, st_l, st_s;
    logic [W-1:0] seen [8];

    burst_stim_gen_if #(.N(N)) bm ();
    burst_stim_gen_if #(.N(N)) bl ();
    burst_stim_gen_if #(.N(N)) bs ();

    logic [N-1:0] rm1, rm2, rl1, rl2;
    always @(posedge clk) begin
        rm1 <= bm.op_a + bm.op_b;
        rm2 <= rm1;
        rl1 <= bl.op_a + bl.op_b;
        rl2 <= rl1;
    end

    assign bm.start  = start_m;
    assign bm.mode   = mode;
    assign bm.sum_in = (sum_sel == 2) ? rm2 : ((bm.op_a + bm.op_b) ^ N'(flip));
    assign bl.start  = start_l;
    assign bl.mode   = mode;
    assign bl.sum_in = rl2;
    assign bs.start  = start_s;
    assign bs.mode   = mode;
    assign bs.sum_in = bs.op_a + bs.op_b;

    burst_stim_gen dut (.clk(clk), .rst(rst), .bus(bm), .state_dbg(st_m));
    burst_stim_gen #(.CHK_LAT(2)) dut_lat (.clk(clk), .rst(rst), .bus(bl), .state_dbg(st_l));
    burst_stim_gen #(.PAYLOAD(1), .GAP(0), .NUM_PKTS(3)) dut_small (
        .clk(clk), .rst(rst), .bus(bs), .state_dbg(st_s));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Model: thermometer word built bit by bit from the phase rules.
    function automatic logic [W-1:0] m_therm(input int p);
        logic [W-1:0] w;
        w = '0;
        for (int b = 0; b < W; b++) begin
            if (p >= 1 && p <= LL)
                w[b] = (b >= W - p * STRIDE);
            else if (p > LL)
                w[b] = (b < (2 * LL + 1 - p) * STRIDE);
        end
        return w;
    endfunction

    function automatic logic [31:0] m_lfsr_next(input logic [31:0] s);
        logic [31:0] mask;
        mask = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
        return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
    endfunction

    function automatic logic [W-1:0] m_word(input int md, input int g, input int idx,
                                            input logic [31:0] lf);
        logic [63:0]  r;
        logic [W-1:0] w;
        w = '0;
        case (md)
            0: w = m_therm((idx + 1) % (2 * LL + 1));
            1: begin
                r = {lf, lf};
                w = r[W-1:0];
            end
            2: w[g % W] = 1'b1;
            default: w = (idx % 2 == 0) ? '1 : '0;
        endcase
        return w;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_op_a"}, bm.op_a, 0);
        chk({tag, "_op_b"}, bm.op_b, 0);
        chk({tag, "_valid"}, bm.flit_valid, 0);
        chk({tag, "_first"}, bm.pkt_first, 0);
        chk({tag, "_last"}, bm.pkt_last, 0);
        chk({tag, "_measure"}, bm.measure_en, 0);
        chk({tag, "_busy"}, bm.busy, 0);
        chk({tag, "_done"}, bm.done, 0);
        chk({tag, "_cycle_cnt"}, bm.cycle_cnt, 0);
        chk({tag, "_err_cnt"}, bm.err_cnt, 0);
    endtask

    task automatic run_main(input int md, input int poke_c, input int f0, input int f1,
                            input int f2, input logic exact, input int exp_err,
                            input logic with_lat);
        logic [W-1:0] last_w, exp_w, obs_w;
        logic [31:0]  lf;
        int pkt, pos, g;
        mode = 2'(md);
        @(posedge clk); #1;
        start_m = 1'b1;
        start_l = with_lat;
        @(posedge clk); #1;
        start_m = 1'b0;
        start_l = 1'b0;
        lf = 32'hACE1;
        last_w = '0;
        for (int c = 0; c < RUN; c++) begin
            pkt = c / (P + G);
            pos = c % (P + G);
            g   = pkt * P + pos;
            start_m = (c == poke_c);
            flip    = (c == f0) || (c == f1) || (c == f2);
            obs_w   = {bm.op_b, bm.op_a};
            chk("measure_en", bm.measure_en, 1);
            chk("busy", bm.busy, 1);
            chk("done_in_run", bm.done, 0);
            chk("cycle_cnt", bm.cycle_cnt, c);
            chk("flit_valid", bm.flit_valid, (pos < P));
            if (pos < P) begin
                exp_w = m_word(md, g, pos, lf);
                lf    = m_lfsr_next(lf);
                chk("pkt_first", bm.pkt_first, (pos == 0));
                chk("pkt_last", bm.pkt_last, (pos == P - 1));
                last_w = exp_w;
            end
            chk("word", obs_w, last_w);
            if (md == 0 && c < 8)
                seen[c] = obs_w;
            @(posedge clk); #1;
        end
        start_m = 1'b0;
        flip    = 1'b0;
        chk("done", bm.done, 1);
        chk("busy_done", bm.busy, 0);
        chk("measure_done", bm.measure_en, 0);
        chk("valid_done", bm.flit_valid, 0);
        chk("cycle_cnt_end", bm.cycle_cnt, RUN);
        chk("word_hold_done", {bm.op_b, bm.op_a}, last_w);
        if (exact)
            chk("err_cnt", bm.err_cnt, exp_err);
        else
            chk("err_nonzero", (bm.err_cnt != 16'd0), 1);
        @(posedge clk); #1;
        chk("measure_after", bm.measure_en, 0);
        chk("done_hold", bm.done, 1);
    endtask

    initial begin
        int poke, fa, fb, fc, md_r;
        rst     = 1'b1;
        start_m = 1'b0;
        start_l = 1'b0;
        start_s = 1'b0;
        mode    = 2'd0;
        flip    = 1'b0;
        sum_sel = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle("reset");
        chk("reset_lat_busy", bl.busy, 0);
        chk("reset_small_valid", bs.flit_valid, 0);

        // Thermometer run with three corrupted sums and an ignored start mid-burst.
        fa   = 0 * (P + G) + $urandom_range(0, P - 1);
        fb   = 3 * (P + G) + $urandom_range(0, P - 1);
        fc   = 6 * (P + G) + $urandom_range(0, P - 1);
        poke = $urandom_range(0, NP - 1) * (P + G) + $urandom_range(1, P - 1);
        run_main(0, poke, fa, fb, fc, 1'b1, 3, 1'b0);
        chk("t1_flit0", seen[0], {21'h1FFE00, 21'h000000});
        chk("t1_flit3", seen[3], {21'h007FFF, 21'h1FFFFF});
        chk("t1_flit6", seen[6], '0);
        chk("t1_flit7", seen[7], {21'h1FFE00, 21'h000000});

        for (int md = 1; md < 4; md++) begin
            poke = $urandom_range(0, NP - 1) * (P + G) + $urandom_range(0, P - 1);
            run_main(md, poke, -1, -1, -1, 1'b1, 0, 1'b0);
        end

        // Two-stage registered adder: latency-2 checker stays clean, latency-0 does not.
        sum_sel = 2;
        run_main(1, -1, -1, -1, -1, 1'b0, 0, 1'b1);
        chk("lat_done", bl.done, 1);
        chk("lat_err_cnt", bl.err_cnt, 0);
        chk("lat_cycle_cnt", bl.cycle_cnt, RUN);
        sum_sel = 0;

        md_r = $urandom_range(0, 3);
        run_main(md_r, -1, -1, -1, -1, 1'b1, 0, 1'b0);

        // Back-to-back single-flit packets.
        mode = 2'd3;
        @(posedge clk); #1;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("small_valid", bs.flit_valid, 1);
            chk("small_first", bs.pkt_first, 1);
            chk("small_last", bs.pkt_last, 1);
            chk("small_word", {bs.op_b, bs.op_a}, {W{1'b1}});
            chk("small_cycle_cnt", bs.cycle_cnt, c);
            @(posedge clk); #1;
        end
        chk("small_done", bs.done, 1);
        chk("small_valid_end", bs.flit_valid, 0);
        chk("small_cycle_end", bs.cycle_cnt, 3);
        chk("small_err", bs.err_cnt, 0);

        // Reset and start in the same cycle: reset wins.
        rst     = 1'b1;
        start_m = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        start_m = 1'b0;
        check_idle("rst_start");
        @(posedge clk); #1;
        chk("rst_start_busy", bm.busy, 0);

        // Reset in the middle of a burst.
        mode = 2'($urandom_range(0, 3));
        start_m = 1'b1;
        @(posedge clk); #1;
        start_m = 1'b0;
        for (int c = 0; c < 2 * (P + G) + 5; c++) begin
            @(posedge clk); #1;
        end
        chk("mid_valid", bm.flit_valid, 1);
        chk("mid_cycle_cnt", bm.cycle_cnt, 2 * (P + G) + 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("mid_rst");
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", bm.flit_valid, 0);
            chk("post_rst_measure", bm.measure_en, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
